// File: rtl/spi_slave_apb_plug_pkg.sv
// Shared types and constants for the SPI-slave-to-APB command plug.
package spi_slave_apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        SETUP  = 3'd3,
        ACCESS = 3'd4,
        RDPUSH = 3'd5
    } state_t;

    localparam int HDR_WRITE_BIT = 31;
    localparam int HDR_LEN_MSB   = 15;
    localparam int WORD_STRIDE   = 4;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/spi_slave_apb_plug_if.sv
// FIFO read/write sides and APB3 master bus seen by the plug.
// Handshake: a word moves on a rising clk edge where valid and ready are both high;
// valid holds its word stable until that edge, and ready never depends on valid.
interface spi_slave_apb_plug_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/spi_slave_apb_plug_timeout.sv
// ACCESS-phase watchdog: loaded in SETUP, counts down in ACCESS, expires on the last cycle.
// Only present when SPI_SLAVE_APB_TIMEOUT_EN is defined.
`ifdef SPI_SLAVE_APB_TIMEOUT_EN
module spi_slave_apb_timeout #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(CYCLES - 1);
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Zero is reached during the CYCLES-th enabled cycle.
    assign expire = enable && (cnt_q == '0);

endmodule
`endif

// File: rtl/spi_slave_apb_plug.sv
// Pops header/address/data words from the RX FIFO and replays them as APB3 transfers;
// read data goes to the TX FIFO. Optional ACCESS timeout: SPI_SLAVE_APB_TIMEOUT_EN.
module spi_slave_apb_plug
    import spi_slave_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    spi_slave_apb_plug_if.master bus,
    output logic                 busy,
    output logic                 err,
    output state_t               state
);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_STRIDE = ADDR_WIDTH'(WORD_STRIDE);
    localparam logic [HDR_LEN_MSB:0]   CNT_ONE     = 1;

    state_t                  state_q, state_d;
    logic                    is_write_q;
    logic [HDR_LEN_MSB:0]    count_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    err_q;

    logic                    rx_ready, tx_valid, psel, penable;
    logic                    rx_fire, tx_fire, last;
    logic                    acc_done, acc_err;
    logic [DATA_WIDTH-1:0]   acc_rdata;

    assign rx_fire = bus.rx_valid && rx_ready;
    assign tx_fire = tx_valid && bus.tx_ready;
    assign last    = (count_q == '0);

`ifdef SPI_SLAVE_APB_TIMEOUT_EN
    logic tmo_expire;

    spi_slave_apb_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .load   (state_q == SETUP),
        .enable (state_q == ACCESS),
        .expire (tmo_expire)
    );

    // A real pready in the expiry cycle wins over the synthetic error.
    assign acc_done  = (state_q == ACCESS) && (bus.pready || tmo_expire);
    assign acc_err   = bus.pready ? bus.pslverr : 1'b1;
    assign acc_rdata = bus.pready ? bus.prdata  : DATA_WIDTH'(TIMEOUT_FILL);
`else
    assign acc_done  = (state_q == ACCESS) && bus.pready;
    assign acc_err   = bus.pslverr;
    assign acc_rdata = bus.prdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_d = ADDR;
            end
            ADDR: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_d = is_write_q ? WDATA : SETUP;
            end
            WDATA: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_d = SETUP;
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (acc_done) begin
                    if (!is_write_q) state_d = RDPUSH;
                    else             state_d = last ? IDLE : WDATA;
                end
            end
            RDPUSH: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) state_d = last ? IDLE : SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; the word count holds N-1 and steps down after each word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            is_write_q <= 1'b0;
            count_q    <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (rx_fire) begin
                    is_write_q <= bus.rx_data[HDR_WRITE_BIT];
                    count_q    <= bus.rx_data[HDR_LEN_MSB:0];
                    err_q      <= 1'b0;
                end
                ADDR: if (rx_fire) begin
                    paddr_q <= {bus.rx_data[ADDR_WIDTH-1:2], 2'b00};
                end
                WDATA: if (rx_fire) begin
                    pwdata_q <= bus.rx_data;
                end
                ACCESS: if (acc_done) begin
                    if (acc_err) err_q <= 1'b1;
                    if (!is_write_q) begin
                        tx_data_q <= acc_rdata;
                    end else if (!last) begin
                        count_q <= count_q - CNT_ONE;
                        paddr_q <= paddr_q + ADDR_STRIDE;
                    end
                end
                RDPUSH: if (tx_fire && !last) begin
                    count_q <= count_q - CNT_ONE;
                    paddr_q <= paddr_q + ADDR_STRIDE;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data_q;
    assign bus.psel     = psel;
    assign bus.penable  = penable;
    assign bus.pwrite   = psel && is_write_q;
    assign bus.paddr    = paddr_q;
    assign bus.pwdata   = pwdata_q;

    assign busy  = (state_q != IDLE);
    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_spi_slave_apb_plug.sv
// Directed + randomized bench for spi_slave_apb_plug with an APB slave model and TX sink.
module tb_spi_slave_apb_plug;
    import spi_slave_apb_pkg::*;

    logic   clk;
    logic   rstn;
    logic   busy;
    logic   err;
    state_t dut_state;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     last_accept_cyc = 0;

    spi_slave_apb_plug_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    spi_slave_apb_plug #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .busy  (busy),
        .err   (err),
        .state (dut_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [31:0] obs_tx_q[$];
    logic [64:0] exp_acc_q[$];
    logic [64:0] obs_acc_q[$];
    logic [31:0] wdat [0:15];
    int          exp_acc_n = 0;
    bit          err_exp = 1'b0;

    // slave / sink knobs
    int          slave_ws = 0;
    int          slave_err_at = -1;
    bit          slave_hang = 1'b0;
    int          acc_idx = 0;
    int          ws_cnt = 0;
    bit          tx_manual = 1'b0;
    bit          rx_gaps = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // APB slave: decides pready/prdata on the falling edge of each ACCESS cycle
    initial begin
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge clk);
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = $urandom;
            if (bus.psel && !bus.penable) begin
                ws_cnt = (slave_ws >= 0) ? slave_ws : $urandom_range(0, 2);
            end else if (bus.psel && bus.penable && !slave_hang) begin
                if (ws_cnt == 0) begin
                    bus.pready  = 1'b1;
                    bus.prdata  = mem_read(bus.paddr);
                    bus.pslverr = (acc_idx == slave_err_at);
                    obs_acc_q.push_back({bus.pwrite, bus.paddr, bus.pwrite ? bus.pwdata : 32'h0});
                    acc_idx++;
                end else begin
                    ws_cnt--;
                end
            end
        end
    end

    // TX FIFO sink
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!tx_manual) bus.tx_ready = ($urandom_range(0, 3) != 0);
        end
    end
    always @(posedge clk) if (bus.tx_valid && bus.tx_ready) obs_tx_q.push_back(bus.tx_data);

    // driver tasks
    task automatic send_word(input logic [31:0] w);
        int t = 0;
        if (rx_gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = w;
        while (!bus.rx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("rx_accept", bus.rx_ready, 1'b1);
        @(posedge clk);
        #1;
        last_accept_cyc = cyc;
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int n);
        logic [31:0] a;
        int start;
        start   = exp_acc_n;
        err_exp = (slave_err_at >= start) && (slave_err_at < start + n);
        for (int i = 0; i < n; i++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_acc_q.push_back({wr, a, wr ? wdat[i] : 32'h0});
            if (!wr) exp_q.push_back(mem_read(a));
        end
        exp_acc_n += n;
        send_word({wr, 15'($urandom), 16'(n - 1)});
        send_word(addr);
        if (wr) for (int i = 0; i < n; i++) send_word(wdat[i]);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    // scoreboard drain
    task automatic drain();
        chk("acc_count", obs_acc_q.size(), exp_acc_q.size());
        while (obs_acc_q.size() > 0 && exp_acc_q.size() > 0)
            chk("apb_access", obs_acc_q.pop_front(), exp_acc_q.pop_front());
        chk("tx_count", obs_tx_q.size(), exp_q.size());
        while (obs_tx_q.size() > 0 && exp_q.size() > 0)
            chk("tx_word", obs_tx_q.pop_front(), exp_q.pop_front());
        obs_acc_q.delete();
        exp_acc_q.delete();
        obs_tx_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_cmd();
        wait_idle();
        chk("err_sticky", err, err_exp);
        drain();
    endtask

    initial begin
        int t;
        logic [31:0] a;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // reset values
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_pwrite", bus.pwrite, 1'b0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_tx_data", bus.tx_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);

        // single write, zero wait states, latency
        slave_ws = 0;
        wdat[0] = 32'hCAFE_0001;
        fork
            run_cmd(1'b1, 32'h1000_0004, 1);
            begin
                t = 0;
                @(negedge clk);
                while (!bus.psel && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("wr_setup_cycle", cyc, last_accept_cyc);
                chk("wr_setup_penable", bus.penable, 1'b0);
                chk("wr_pwrite", bus.pwrite, 1'b1);
                chk("wr_paddr", bus.paddr, 32'h1000_0004);
                chk("wr_pwdata", bus.pwdata, 32'hCAFE_0001);
                @(negedge clk);
                chk("wr_access_psel", bus.psel, 1'b1);
                chk("wr_access_penable", bus.penable, 1'b1);
                @(negedge clk);
                chk("wr_done_psel", bus.psel, 1'b0);
                chk("wr_done_pwrite", bus.pwrite, 1'b0);
                chk("wr_done_rx_ready", bus.rx_ready, 1'b1);
                chk("wr_done_busy", busy, 1'b0);
            end
        join
        finish_cmd();

        // three-word read with a directed slave memory
        mem[32'h2000_0000] = 32'h11;
        mem[32'h2000_0004] = 32'h22;
        mem[32'h2000_0008] = 32'h33;
        run_cmd(1'b0, 32'h2000_0000, 3);
        finish_cmd();

        // read of 2 with TX back-pressure
        tx_manual = 1'b1;
        bus.tx_ready = 1'b0;
        a = 32'h3000_0040;
        run_cmd(1'b0, a, 2);
        t = 0;
        while (!bus.tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_tx_valid", bus.tx_valid, 1'b1);
            chk("bp_tx_data", bus.tx_data, mem_read(a));
            chk("bp_no_setup", bus.psel, 1'b0);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_setup_psel", bus.psel, 1'b1);
        chk("bp_next_setup_penable", bus.penable, 1'b0);
        chk("bp_next_paddr", bus.paddr, a + 32'h4);
        chk("bp_tx_valid_drop", bus.tx_valid, 1'b0);
        tx_manual = 1'b0;
        finish_cmd();

        // write of 2 with 3 wait states and slverr on the first word
        slave_ws = 3;
        slave_err_at = acc_idx;
        wdat[0] = 32'h0BAD_0001;
        wdat[1] = 32'h0BAD_0002;
        a = 32'h4000_0100;
        fork
            run_cmd(1'b1, a, 2);
            begin
                t = 0;
                @(negedge clk);
                while (!(bus.psel && bus.penable) && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                for (int i = 0; i < 3; i++) begin
                    chk("ws_psel", bus.psel, 1'b1);
                    chk("ws_penable", bus.penable, 1'b1);
                    chk("ws_paddr", bus.paddr, a);
                    chk("ws_pwdata", bus.pwdata, 32'h0BAD_0001);
                    @(negedge clk);
                end
                @(negedge clk);
                chk("err_after_word1", err, 1'b1);
            end
        join
        finish_cmd();

        // address wrap; the new header also clears err
        slave_ws = 0;
        slave_err_at = -1;
        run_cmd(1'b0, 32'hFFFF_FFFC, 2);
        finish_cmd();

        // reset asserted in ACCESS
        slave_hang = 1'b1;
        wdat[0] = 32'h5555_AAAA;
        send_word(32'h8000_0000);
        send_word(32'h5000_0000);
        send_word(wdat[0]);
        t = 0;
        while (!(bus.psel && bus.penable) && t < 200) begin
            @(negedge clk);
            t++;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_psel", bus.psel, 1'b0);
        chk("mid_rst_penable", bus.penable, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        slave_hang = 1'b0;
        drain();

`ifdef SPI_SLAVE_APB_TIMEOUT_EN
        // slave never answers: 16 ACCESS cycles then a synthetic error
        slave_hang = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'h0000_0000);
        send_word(32'h6000_0000);
        t = 0;
        while (!bus.penable && t < 200) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (bus.penable && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_access_cycles", t, 16);
        wait_idle();
        chk("tmo_err", err, 1'b1);
        drain();
        slave_hang = 1'b0;
`endif

        // randomized back-to-back commands
        slave_ws = -1;
        rx_gaps = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 16; i++) wdat[i] = $urandom;
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 4));
        end
        finish_cmd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
